// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed restoring divider producing quotient (lo) and remainder (hi).
// Optional macro DIV_UNSIGNED_EN adds an is_unsigned input selecting unsigned division.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef DIV_UNSIGNED_EN
    input  logic        is_unsigned,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [63:0] pr;
    logic [31:0] dvsr;
    logic [5:0]  cnt;
    logic        neg_q, neg_r;
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [63:0] pr_sh;
    logic [32:0] trial;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    assign a_neg = signed_op & a[31];
    assign b_neg = signed_op & b[31];
    assign abs_a = a_neg ? (32'd0 - a) : a;
    assign abs_b = b_neg ? (32'd0 - b) : b;

    // Partial remainder never reaches the divisor, so the shifted upper half fits in 32 bits.
    assign pr_sh = {pr[62:0], 1'b0};
    assign trial = {1'b0, pr_sh[63:32]} - {1'b0, dvsr};

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: if (start) state_nxt = (b == 32'd0) ? DONE : CALC;
            CALC: if (cnt == 6'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pr       <= 64'd0;
            dvsr     <= 32'd0;
            cnt      <= 6'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            div_zero <= 1'b1;
                        end else begin
                            div_zero <= 1'b0;
                            pr       <= {32'd0, abs_a};
                            dvsr     <= abs_b;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            cnt      <= 6'd0;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (!trial[32])
                        pr <= {trial[31:0], pr_sh[31:1], 1'b1};
                    else
                        pr <= pr_sh;
                end
                FIX: begin
                    lo <= neg_q ? (32'd0 - pr[31:0])  : pr[31:0];
                    hi <= neg_r ? (32'd0 - pr[63:32]) : pr[63:32];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
`ifdef DIV_UNSIGNED_EN
    logic        is_unsigned = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lo = 32'd0, m_hi = 32'd0;
    logic        m_dz = 1'b0;

    div_unit dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned(is_unsigned),
`endif
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic sidesteps the 0x80000000 / -1 overflow.
    task automatic model(input logic [31:0] ia, input logic [31:0] ib, input logic uns);
        longint sa, sb, q, r;
        if (ib == 32'd0) begin
            m_dz = 1'b1;
        end else begin
            sa = uns ? longint'({32'd0, ia}) : longint'($signed(ia));
            sb = uns ? longint'({32'd0, ib}) : longint'($signed(ib));
            q  = sa / sb;
            r  = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
            m_dz = 1'b0;
        end
    endtask

    // Called at a negedge; runs a fixed window so stray extra done pulses are counted.
    task automatic do_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic uns, input int repulse);
        int lat, busy_n, dones;
        lat = 0; busy_n = 0; dones = 0;
        a = ia; b = ib; start = 1'b1;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = uns;
`endif
        model(ia, ib, uns);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (busy) busy_n++;
            if (done) begin
                dones++;
                if (lat == 0) lat = n;
            end
            if (n == repulse) begin
                a = $urandom; b = $urandom; start = 1'b1;
`ifdef DIV_UNSIGNED_EN
                is_unsigned = ~uns;
`endif
            end else if (n == repulse + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " lat"}, 32'(lat), (ib == 32'd0) ? 32'd1 : 32'd34);
        check({tag, " busy"}, 32'(busy_n), (ib == 32'd0) ? 32'd1 : 32'd34);
        check({tag, " dones"}, 32'(dones), 32'd1);
        check({tag, " lo"}, lo, m_lo);
        check({tag, " hi"}, hi, m_hi);
        check({tag, " dz"}, {31'd0, div_zero}, {31'd0, m_dz});
    endtask

    initial begin
        logic [31:0] ra, rb;
        int dones;
        repeat (3) @(negedge clk);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        do_op("100/7", 32'd100, 32'd7, 1'b0, -5);
        do_op("5/0", 32'd5, 32'd0, 1'b0, -5);
        do_op("-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, -5);
        check("-7/2 lo const", lo, 32'hFFFF_FFFD);
        check("-7/2 hi const", hi, 32'hFFFF_FFFF);
        do_op("7/-2", 32'd7, 32'hFFFF_FFFE, 1'b0, -5);
        check("7/-2 lo const", lo, 32'hFFFF_FFFD);
        check("7/-2 hi const", hi, 32'd1);
        do_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -5);
        check("min/-1 lo const", lo, 32'h8000_0000);
`ifdef DIV_UNSIGNED_EN
        do_op("umin/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -5);
        check("umin/max hi const", hi, 32'h8000_0000);
`endif
        do_op("repulse", 32'd1000, 32'd33, 1'b0, 5);
        do_op("repulse late", 32'hFFFF_FC18, 32'd33, 1'b0, 33);

        // Mid-CALC abort.
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        m_lo = 32'd0; m_hi = 32'd0; m_dz = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort no done", 32'(dones), 32'd0);
        do_op("9/3", 32'd9, 32'd3, 1'b0, -5);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 6)
                0: rb = 32'd0;
                1: rb = $urandom_range(15, 1);
                2: rb = 32'd0 - 32'($urandom_range(15, 1));
                3: ra = $urandom_range(20, 0);
                default: ;
            endcase
`ifdef DIV_UNSIGNED_EN
            do_op("rand", ra, rb, 1'($urandom_range(1, 0)), -5);
`else
            do_op("rand", ra, rb, 1'b0, -5);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, with ports as follows (clock and reset first):
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 a  input  32  dividend, two's complement.
REQ-006 b  input  32  divisor, two's complement.
REQ-007 hi  output  32  remainder register, feeds the div/mult result selector.
REQ-008 lo  output  32  quotient register, feeds the div/mult result selector.
REQ-009 busy  output  1  high while in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse: result (or div-by-zero) is valid.
REQ-011 div_zero  output  1  sticky flag: last accepted operation had b == 0.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE, with IDLE as the reset state.
REQ-013 In IDLE with start=1 and b!=0 at edge E0, the block SHALL latch |a|, |b| and the operand signs, clear div_zero, zero a 6-bit counter, and enter CALC.
REQ-014 In IDLE with start=1 and b==0 at E0, the block SHALL set div_zero=1, leave hi and lo unchanged, and enter DONE.
REQ-015 In CALC, the block SHALL perform one restoring shift-subtract step per cycle on 32-bit magnitudes (64-bit partial remainder), and SHALL enter FIX after exactly 32 steps (edge E32).
REQ-016 In FIX, the block SHALL write lo = quotient (negated if the operand signs differ) and hi = remainder (negated if a < 0), then enter DONE.
REQ-017 Results SHALL follow truncation toward zero, with the remainder taking the sign of the dividend.
REQ-018 For a = 0x80000000 and b = 0xFFFFFFFF, the block SHALL produce lo = 0x80000000 and hi = 0 without any flag.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-020 Latency SHALL be as follows: for a normal operation, done is high in the cycle after E33; for b == 0, done is high in the cycle after E0.
REQ-021 hi, lo and div_zero SHALL hold their values until the next accepted start; a, b and start changes outside IDLE SHALL have no effect.
REQ-022 start held high continuously SHALL launch a new operation on each return to IDLE; a back-to-back start in DONE SHALL be ignored.
REQ-023 busy SHALL be 1 in CALC, FIX and DONE, and SHALL fall in the same cycle the FSM returns to IDLE.

Reset
REQ-024 When reset = 0, the block SHALL asynchronously force the FSM to IDLE, set hi, lo and the counter to 0, and drive done, busy and div_zero to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow, and the next start SHALL begin a fresh division.
REQ-026 Reset deassertion SHALL take effect at the next rising edge, with no output glitches before the first accepted start.

Configuration
REQ-027 Macro DIV_UNSIGNED_EN, when defined, SHALL add the input port is_unsigned (1 bit, sampled with start); when is_unsigned = 1, operands are treated as unsigned magnitudes, sign fixup in FIX is skipped, and the 0x80000000 / 0xFFFFFFFF case yields lo = 0, hi = 0x80000000.
REQ-028 When DIV_UNSIGNED_EN is undefined, the block SHALL have no is_unsigned port and all divisions SHALL be signed per REQ-013..REQ-018.

Verification
REQ-029 The bench SHALL cover: a = 100, b = 7, start pulse -> busy for 34 cycles, done in the cycle after E33, lo = 14, hi = 2, div_zero = 0.
REQ-030 The bench SHALL cover: a = -7 (0xFFFFFFF9), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; and a = 7, b = -2 -> lo = 0xFFFFFFFD, hi = 1.
REQ-031 The bench SHALL cover: prior result lo = 14, hi = 2, then a = 5, b = 0 -> done in the cycle after E0, div_zero = 1, lo = 14, hi = 2 unchanged; the next valid start clears div_zero.
REQ-032 The bench SHALL cover: a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0; with DIV_UNSIGNED_EN and is_unsigned = 1 -> lo = 0, hi = 0x80000000.
REQ-033 The bench SHALL cover: reset asserted 10 cycles into CALC -> hi = lo = 0, busy = done = 0 immediately, no later done; a subsequent a = 9, b = 3 -> lo = 3, hi = 0.
REQ-034 The bench SHALL cover: start re-pulsed with new operands while busy -> ignored, so results match the original operands and exactly one done is produced.
